// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history/target table.
// Fetch looks up f_pc combinationally for a predicted next PC. Decode reports each
// resolved control-flow instruction; the block flags a mispredict, supplies the
// redirect PC and trains the table at the clock edge.
// Optional build macro BP_STATS_EN adds branch and mispredict event counters.
module branch_predictor_bht #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 10,
    parameter int unsigned CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic [63:0] f_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [63:0] pred_target,
    input  logic        u_valid,
    input  logic [63:0] u_pc,
    input  logic        u_is_cond,
    input  logic        u_taken,
    input  logic [63:0] u_target,
    input  logic        u_pred_taken,
    input  logic [63:0] u_pred_target,
    output logic        mispredict,
    output logic [63:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredict
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [63:0]      target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    logic             wr_en;
    logic [CNT_W-1:0] wr_cnt;
    logic [63:0]      wr_target;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch-side lookup; reads pre-update contents (no write bypass).
    always_comb begin
        pred_hit    = f_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = pred_hit && cnt_q[f_idx][CNT_W-1];
        pred_target = pred_taken ? target_q[f_idx] : f_pc + 64'd4;
    end

    // Resolution: compare actual outcome with the prediction carried down the pipe.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 64'd0;
        if (u_valid) begin
            mispredict  = (u_taken != u_pred_taken) ||
                          (u_taken && (u_target != u_pred_target));
            redirect_pc = u_taken ? u_target : u_pc + 64'd4;
        end
    end

    // Training: compute the new contents of the single entry touched this cycle.
    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        wr_en     = 1'b0;
        wr_cnt    = cnt_q[u_idx];
        wr_target = target_q[u_idx];
        if (u_valid) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (u_is_cond) begin
                    if (u_taken) begin
                        if (cnt_q[u_idx] != CNT_MAX) wr_cnt = cnt_q[u_idx] + 1'b1;
                        wr_target = u_target;
                    end else if (cnt_q[u_idx] != '0) begin
                        wr_cnt = cnt_q[u_idx] - 1'b1;
                    end
                end else begin
                    wr_cnt    = CNT_MAX;
                    wr_target = u_target;
                end
            end else if (u_taken) begin
                // Allocate, overwriting any aliased entry at this index.
                wr_en     = 1'b1;
                wr_cnt    = u_is_cond ? CNT_WEAK : CNT_MAX;
                wr_target = u_target;
            end
        end
    end

    // Table storage; reset clears every entry and overrides a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                cnt_q[i]    <= '0;
                target_q[i] <= 64'd0;
            end
        end else if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            cnt_q[u_idx]    <= wr_cnt;
            target_q[u_idx] <= wr_target;
        end
    end

`ifdef BP_STATS_EN
    // Event counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches   <= 32'd0;
            stat_mispredict <= 32'd0;
        end else begin
            if (u_valid) stat_branches <= stat_branches + 32'd1;
            if (mispredict) stat_mispredict <= stat_mispredict + 32'd1;
        end
    end
`endif

endmodule
